// File: rtl/sudoku_hex_serializer.sv
// ----------------------------------------------------------------------------
// sudoku_hex_serializer
//
// Captures an 81-cell packed hex sudoku grid (4 bits per cell) on a start
// pulse into a private shadow register. It then streams the grid out in
// row-major order over a valid/ready interface, one symbol per cycle.
//
// ASCII_MODE = 0 : raw digit on out_data[3:0], 81 symbols per grid.
// ASCII_MODE = 1 : '.', '1'..'9' or '?' per cell, plus a newline after each
//                  row, 90 symbols per grid.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   hex_in     : packed grid, cell i = hex_in[i*4+3:i*4], row=i/9, col=i%9
//   start      : capture request, only honoured while idle
//   busy       : a grid is being streamed (identical to out_valid)
//   out_valid  : symbol available
//   out_ready  : consumer accepts the symbol
//   out_data   : symbol byte
//   out_row    : row of the current symbol (0..8)
//   out_col    : column of the current symbol (0..8), 9 for a newline
//   out_eol    : current symbol is a newline (ASCII mode only)
//   out_last   : current symbol is the final symbol of the grid
//
// All outputs are decoded from registered state only; out_ready and start
// steer the next state but never reach an output combinationally.
// ----------------------------------------------------------------------------
module sudoku_hex_serializer #(
  parameter int unsigned ASCII_MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [323:0] hex_in,
  input  logic         start,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic [3:0]   out_row,
  output logic [3:0]   out_col,
  output logic         out_eol,
  output logic         out_last
);

  localparam bit ASCII = (ASCII_MODE != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_EOL
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [323:0]   r_shadow;
  logic [323:0]   w_shadow_nxt;
  logic [3:0]     r_row;
  logic [3:0]     w_row_nxt;
  logic [3:0]     r_col;
  logic [3:0]     w_col_nxt;

  logic           w_fire;
  logic [6:0]     w_cell;
  logic [3:0]     w_digit;
  logic [7:0]     w_char;

  // Current cell index and its digit from the shadow copy.
  assign w_cell  = 7'(r_row) * 7'd9 + 7'(r_col);
  assign w_digit = r_shadow[{w_cell, 2'b00} +: 4];

  // Handshake; out_valid is itself a decode of r_state.
  assign w_fire  = out_valid && out_ready;

  // Symbol encoding for a data cell.
  always_comb begin
    w_char = '0;
    if (!ASCII) begin
      w_char = {4'h0, w_digit};
    end else if (w_digit == 4'd0) begin
      w_char = 8'h2E;
    end else if (w_digit <= 4'd9) begin
      w_char = 8'h30 + {4'h0, w_digit};
    end else begin
      w_char = 8'h3F;
    end
  end

  // Output decode: everything is zero while idle.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    out_eol   = 1'b0;
    out_last  = 1'b0;
    unique case (r_state)
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = w_char;
        out_row   = r_row;
        out_col   = r_col;
        out_last  = !ASCII && (r_row == 4'd8) && (r_col == 4'd8);
      end
      S_EOL: begin
        out_valid = 1'b1;
        out_data  = 8'h0A;
        out_row   = r_row;
        out_col   = 4'd9;
        out_eol   = 1'b1;
        out_last  = (r_row == 4'd8);
      end
      default: begin
      end
    endcase
    busy = out_valid;
  end

  // Next-state logic. Leaving the stream clears row/col/shadow so the idle
  // state always looks like the reset state.
  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_shadow_nxt = r_shadow;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_shadow_nxt = hex_in;
          w_row_nxt    = '0;
          w_col_nxt    = '0;
          w_state_nxt  = S_SEND;
        end
      end
      S_SEND: begin
        if (w_fire) begin
          if (r_col < 4'd8) begin
            w_col_nxt = r_col + 4'd1;
          end else if (ASCII) begin
            w_state_nxt = S_EOL;
          end else if (r_row < 4'd8) begin
            w_row_nxt = r_row + 4'd1;
            w_col_nxt = '0;
          end else begin
            w_state_nxt  = S_IDLE;
            w_row_nxt    = '0;
            w_col_nxt    = '0;
            w_shadow_nxt = '0;
          end
        end
      end
      S_EOL: begin
        if (w_fire) begin
          if (r_row < 4'd8) begin
            w_row_nxt   = r_row + 4'd1;
            w_col_nxt   = '0;
            w_state_nxt = S_SEND;
          end else begin
            w_state_nxt  = S_IDLE;
            w_row_nxt    = '0;
            w_col_nxt    = '0;
            w_shadow_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_row_nxt    = '0;
        w_col_nxt    = '0;
        w_shadow_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

endmodule
